nibble_array_collector: RTL and testbench
=========================================

// Module: nibble_array_collector
//
// PURPOSE
//   Upstream feeder for the unpacked-port windowing stage. Accepts a stream
//   of W-bit nibbles over a valid/ready handshake and assembles N of them
//   into an unpacked array arr_out[N] plus a packed view.
//   The downstream stage slices arr_out into overlapping 3-entry windows.
//   Provides frame framing, abort and backpressure.
//
// PARAMETERS
//   W   4   width of one array element (bits)
//   N   5   elements per frame (N >= 2)
//
// PORTS
//   clk         input   1        rising-edge clock
//   rst         input   1        synchronous reset, active-high
//   in_valid    input   1        in_data is valid this cycle
//   in_ready    output  1        collector accepts in_data this cycle
//   in_data     input   W        next element of the current frame
//   in_abort    input   1        discard partial frame (honoured in FILL only)
//   arr_out     output  W x [N]  unpacked frame; arr_out[i] = i-th element accepted
//   packed_out  output  N*W      {arr_out[N-1], ..., arr_out[0]}
//   arr_valid   output  1        arr_out holds a complete frame
//   arr_ready   input   1        consumer takes the frame this cycle
//   fill_cnt    output  $clog2(N+1)  elements held in the current frame
//   frame_cnt   output  8        completed frames handed off, wraps 255->0
//
// BEHAVIOUR
//   Reset (rst=1 at posedge)
//     - State FILL; idx=0; all arr_out entries 0; arr_valid=0; fill_cnt=0; frame_cnt=0.
//     - in_ready is forced to 0 while rst is high. The rst level overrides all other inputs.
//   Accept condition: acc = in_valid & in_ready. Drain condition: drn = arr_valid & arr_ready.
//   FILL (arr_valid=0, in_ready=1)
//     - acc: arr_out[idx] <= in_data and idx <= idx+1.
//     - If acc occurs with idx==N-1, the next state is HOLD and arr_valid <= 1 in the next cycle.
//     - in_abort=1 returns idx to 0. Any acc in the same cycle is dropped (abort wins).
//     - Contents of arr_out are not cleared by abort.
//     - Entries at index >= idx hold stale data and are don't-care until arr_valid.
//   HOLD (arr_valid=1, in_ready = arr_ready)
//     - arr_out, packed_out and arr_valid stay stable until drn.
//     - in_abort is ignored.
//     - drn without acc: next state FILL, idx=0, frame_cnt+1.
//     - drn with acc (back-to-back): arr_out[0] <= in_data, idx=1, next state FILL, frame_cnt+1.
//     - With N... note: frame completion then takes N-1 more accepts.
//   Latency
//     - arr_valid rises the cycle after the N-th accept.
//     - Minimum frame period is N cycles under continuous valid/ready.
//   fill_cnt = idx in FILL and N in HOLD. It is a registered, combinationally-derived view.
//   frame_cnt increments by 1 per drn and wraps modulo 256.
//   Reset mid-frame or mid-HOLD: the frame is dropped, no drn is counted, and all reset values apply.
//   No X propagation: outputs are defined every cycle after the first reset.
//
// TESTING
//   1. Reset, stream nibbles 0..4 with arr_ready=1.
//      -> arr_valid is high 1 cycle after the 5th accept.
//      -> packed_out=20'h43210, arr_out[2]=4'h2, frame_cnt=1.
//   2. Frame A..E complete, hold arr_ready=0 for 10 cycles.
//      -> in_ready=0 and arr_out stable.
//      -> Raise arr_ready with in_valid=1, data 7: next cycle arr_out[0]=7, fill_cnt=1.
//   3. Accept 3 nibbles, assert in_abort with in_valid=1.
//      -> fill_cnt=0 and the nibble is dropped.
//      -> The next 5 nibbles 9,8,7,6,5 give packed_out=20'h56789.
//   4. Continuous stream of 1280 nibbles with arr_ready=1.
//      -> 256 frames, frame_cnt wraps to 0, arr_valid pulses every 5 cycles.
//   5. Assert rst while in HOLD, with fill_cnt=3 in a second run.
//      -> arr_valid=0, arr_out all 0, fill_cnt=0, frame_cnt=0, in_ready=0 during rst.
//   6. Random valid/arr_ready/abort for 10k cycles.
//      -> Scoreboard matches packed_out per frame.
//      -> No change of arr_out while arr_valid & !arr_ready.

Source files
------------

// File: rtl/nibble_array_collector.sv
// Collects N W-bit elements from a valid/ready stream into an unpacked frame
// and presents it downstream until consumed; supports abort and backpressure.
module nibble_array_collector #(
    parameter int W = 4,
    parameter int N = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [W-1:0]              in_data,
    input  logic                      in_abort,
    output logic [W-1:0]              arr_out [N],
    output logic [N*W-1:0]            packed_out,
    output logic                      arr_valid,
    input  logic                      arr_ready,
    output logic [$clog2(N+1)-1:0]    fill_cnt,
    output logic [7:0]                frame_cnt
);
    localparam int CW = $clog2(N+1);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] idx;
    logic          acc;
    logic          drn;

    // While holding a frame, a new element may only enter as the old one leaves.
    assign in_ready  = !rst && ((state == FILL) || arr_ready);
    assign arr_valid = (state == HOLD);
    assign acc       = in_valid && in_ready;
    assign drn       = arr_valid && arr_ready;
    assign fill_cnt  = (state == HOLD) ? CW'(N) : idx;

    always_comb begin
        packed_out = '0;
        for (int i = 0; i < N; i++) begin
            packed_out[i*W +: W] = arr_out[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FILL;
            idx       <= '0;
            frame_cnt <= '0;
            for (int i = 0; i < N; i++) begin
                arr_out[i] <= '0;
            end
        end else if (state == FILL) begin
            // Abort discards the partial frame and wins over a same-cycle accept.
            if (in_abort) begin
                idx <= '0;
            end else if (acc) begin
                arr_out[idx] <= in_data;
                if (idx == CW'(N-1)) begin
                    state <= HOLD;
                    idx   <= '0;
                end else begin
                    idx <= idx + 1'b1;
                end
            end
        end else if (drn) begin
            frame_cnt <= frame_cnt + 8'd1;
            state     <= FILL;
            if (acc) begin
                arr_out[0] <= in_data;
                idx        <= CW'(1);
            end else begin
                idx <= '0;
            end
        end
    end
endmodule

// File: tb/tb_nibble_array_collector.sv
// Directed and random stimulus for nibble_array_collector; a queue scoreboard
// holds expected frames and a negedge monitor checks each presented frame.
module tb_nibble_array_collector;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  in_data = '0;
    logic        in_abort = 1'b0;
    logic [3:0]  arr_out [5];
    logic [19:0] packed_out;
    logic        arr_valid;
    logic        arr_ready = 1'b0;
    logic [2:0]  fill_cnt;
    logic [7:0]  frame_cnt;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int nvld = 0;

    logic [19:0] sb[$];
    logic [19:0] mpk = '0;
    int          midx = 0;
    logic [19:0] held = '0;
    bit          seen = 0;

    nibble_array_collector #(.W(4), .N(5)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_abort(in_abort), .arr_out(arr_out),
        .packed_out(packed_out), .arr_valid(arr_valid), .arr_ready(arr_ready),
        .fill_cnt(fill_cnt), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void accept(input logic [3:0] d);
        mpk[midx*4 +: 4] = d;
        midx++;
        if (midx == 5) begin
            sb.push_back(mpk);
            midx = 0;
        end
    endfunction

    // Monitor: pop one expected frame when a frame first appears, then
    // require it to stay stable until the consumer takes it.
    always @(negedge clk) begin
        if (rst) begin
            seen = 0;
        end else if (arr_valid) begin
            if (!seen) begin
                if (sb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_frame: got %h expected none", packed_out);
                end else begin
                    chk("frame", 32'(packed_out), 32'(sb.pop_front()));
                end
                held = packed_out;
                seen = 1;
                nvld++;
            end else begin
                chk("hold_stable", 32'(packed_out), 32'(held));
            end
            if (arr_ready) seen = 0;
        end else begin
            seen = 0;
        end
    end

    task automatic send(input logic [3:0] d);
        bit ok;
        ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                accept(d);
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            total++; bad++;
            $display("FAIL send_timeout: got no in_ready expected in_ready within 100 cycles");
        end
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_arr_valid"}, 32'(arr_valid), 32'd0);
        chk({tag, "_fill_cnt"}, 32'(fill_cnt), 32'd0);
        chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'd0);
        chk({tag, "_packed"}, 32'(packed_out), 32'd0);
        for (int i = 0; i < 5; i++) chk({tag, "_arr_out"}, 32'(arr_out[i]), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1; in_valid = 1'b0; in_abort = 1'b0;
        @(negedge clk);
        chk({tag, "_rst_in_ready"}, 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        midx = 0;
        check_reset_state(tag);
    endtask

    initial begin
        int t0;
        // Test 1: basic frame 0..4
        do_reset("reset");
        arr_ready = 1'b1;
        for (int i = 0; i < 5; i++) send(4'(i));
        chk("t1_arr_valid", 32'(arr_valid), 32'd1);
        chk("t1_packed", 32'(packed_out), 32'h43210);
        chk("t1_arr_out2", 32'(arr_out[2]), 32'h2);
        chk("t1_fill_cnt_hold", 32'(fill_cnt), 32'd5);
        @(posedge clk); #1;
        chk("t1_frame_cnt", 32'(frame_cnt), 32'd1);
        chk("t1_valid_low", 32'(arr_valid), 32'd0);

        // Test 2: backpressure then back-to-back handoff
        arr_ready = 1'b0;
        send(4'hA); send(4'hB); send(4'hC); send(4'hD); send(4'hE);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t2_in_ready", 32'(in_ready), 32'd0);
            chk("t2_packed", 32'(packed_out), 32'hEDCBA);
            chk("t2_arr_valid", 32'(arr_valid), 32'd1);
            @(posedge clk); #1;
        end
        arr_ready = 1'b1;
        send(4'h7);
        chk("t2_arr_out0", 32'(arr_out[0]), 32'h7);
        chk("t2_fill_cnt", 32'(fill_cnt), 32'd1);
        chk("t2_frame_cnt", 32'(frame_cnt), 32'd2);
        chk("t2_valid_low", 32'(arr_valid), 32'd0);

        // Test 3: abort beats a simultaneous accept
        send(4'h1); send(4'h2); send(4'h3);
        chk("t3_fill_before", 32'(fill_cnt), 32'd4);
        in_abort = 1'b1; in_valid = 1'b1; in_data = 4'hF;
        @(negedge clk);
        midx = 0;
        @(posedge clk); #1;
        in_abort = 1'b0; in_valid = 1'b0;
        chk("t3_fill_abort", 32'(fill_cnt), 32'd0);
        send(4'h9); send(4'h8); send(4'h7); send(4'h6); send(4'h5);
        chk("t3_packed", 32'(packed_out), 32'h56789);
        chk("t3_arr_out4", 32'(arr_out[4]), 32'h5);

        // Test 4: 1280 nibbles streamed continuously, frame_cnt wraps
        do_reset("t4");
        arr_ready = 1'b1;
        nvld = 0;
        t0 = cyc;
        for (int i = 0; i < 1280; i++) send(4'(i * 3 + 1));
        chk("t4_cycles", 32'(cyc - t0), 32'd1280);
        @(negedge clk);
        @(posedge clk); #1;
        chk("t4_frames", 32'(nvld), 32'd256);
        chk("t4_frame_cnt_wrap", 32'(frame_cnt), 32'd0);

        // Test 5: reset while holding, then reset with a partial frame
        arr_ready = 1'b0;
        for (int i = 0; i < 5; i++) send(4'(i + 8));
        chk("t5_hold", 32'(arr_valid), 32'd1);
        do_reset("t5a");
        arr_ready = 1'b1;
        send(4'h3); send(4'h4); send(4'h5);
        chk("t5_fill3", 32'(fill_cnt), 32'd3);
        do_reset("t5b");

        // Test 6: random valid / ready / abort
        for (int c = 0; c < 10000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            arr_ready = 1'($urandom_range(0, 1));
            in_abort  = ($urandom_range(0, 15) == 0);
            in_data   = 4'($urandom);
            @(negedge clk);
            if (!arr_valid && in_abort) midx = 0;
            else if (in_valid && in_ready) accept(in_data);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; in_abort = 1'b0; arr_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("t6_sb_drained", 32'(sb.size()), 32'd0);
        chk("t6_valid_idle", 32'(arr_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
